// File: rtl/div_arbiter.sv
// div_arbiter
// Shares one sequential divider core (start/ready/done-tick interface) between
// N requesters. Requests are granted round-robin, the winner's operands are
// registered and handed to the core with a one-cycle start pulse, and the
// core's quotient/remainder are returned to the owning requester. A watchdog
// aborts a transaction whose done tick never arrives and reports it through
// rsp_err.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid[N]           per-requester request pending
//   req_dvnd/req_dvsr      packed operands, requester i at [i*W +: W]
//   req_ready[N]           one-cycle accept pulse to the granted requester
//   rsp_valid[N]           one-cycle result pulse to the owning requester
//   rsp_quo/rsp_rmd        shared result buses, valid with rsp_valid
//   rsp_err                timeout flag, valid with rsp_valid
//   div_start              start pulse to the core
//   div_dvnd/div_dvsr      registered operands to the core
//   div_quo/div_rmd        core results
//   div_ready, div_done    core idle flag and one-cycle completion tick
//   busy                   transaction in progress
//   owner                  index of current or last granted requester
module div_arbiter #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int IW  = 2,
    parameter int TMO = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_dvnd,
    input  logic [N*W-1:0]  req_dvsr,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [W-1:0]    rsp_quo,
    output logic [W-1:0]    rsp_rmd,
    output logic            rsp_err,
    output logic            div_start,
    output logic [W-1:0]    div_dvnd,
    output logic [W-1:0]    div_dvsr,
    input  logic [W-1:0]    div_quo,
    input  logic [W-1:0]    div_rmd,
    input  logic            div_ready,
    input  logic            div_done,
    output logic            busy,
    output logic [IW-1:0]   owner
);

    localparam int WDW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [WDW-1:0]  wd_inc;
    logic [W-1:0]    dvnd_q, dvnd_d;
    logic [W-1:0]    dvsr_q, dvsr_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rmd_q, rmd_d;
    logic            err_q, err_d;

    logic            found;
    logic            grant;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;

    // Round-robin search: first pending requester starting at rr_ptr, wrapping mod N.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % N);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Reset is included so req_ready reads zero while reset is held, even with
    // requests pending and the core idle.
    assign grant = (state_q == IDLE) && found && div_ready && !reset;

    // Next-state and Moore outputs.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        wd_d      = wd_q;
        dvnd_d    = dvnd_q;
        dvsr_d    = dvsr_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        wd_inc    = wd_q + WDW'(1);

        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready = N'(1) << winner;
                    dvnd_d    = req_dvnd[winner*W +: W];
                    dvsr_d    = req_dvsr[winner*W +: W];
                    owner_d   = winner;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                div_start = 1'b1;
                wd_d      = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                wd_d = wd_inc;
                // A done tick in the timeout cycle still counts as a normal result.
                if (div_done) begin
                    quo_d   = div_quo;
                    rmd_d   = div_rmd;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_inc == WDW'(TMO - 1)) begin
                    quo_d   = '0;
                    rmd_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = N'(1) << owner_q;
                rr_ptr_d  = IW'((int'(owner_q) + 1) % N);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wd_q     <= '0;
            dvnd_q   <= '0;
            dvsr_q   <= '0;
            quo_q    <= '0;
            rmd_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wd_q     <= wd_d;
            dvnd_q   <= dvnd_d;
            dvsr_q   <= dvsr_d;
            quo_q    <= quo_d;
            rmd_q    <= rmd_d;
            err_q    <= err_d;
        end
    end

    assign div_dvnd = dvnd_q;
    assign div_dvsr = dvsr_q;
    assign rsp_quo  = quo_q;
    assign rsp_rmd  = rmd_q;
    assign rsp_err  = err_q;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
// Directed bench for div_arbiter with a behavioural divider core whose latency
// is set per transaction. Expected responses are queued when a request is
// driven and compared when rsp_valid pulses.
module tb_div_arbiter;

    localparam int W   = 12;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int TMO = 16;
    localparam int D   = W + 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_dvnd;
    logic [N*W-1:0]  req_dvsr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_quo;
    logic [W-1:0]    rsp_rmd;
    logic            rsp_err;
    logic            div_start;
    logic [W-1:0]    div_dvnd;
    logic [W-1:0]    div_dvsr;
    logic [W-1:0]    div_quo;
    logic [W-1:0]    div_rmd;
    logic            div_ready;
    logic            div_done;
    logic            busy;
    logic [IW-1:0]   owner;

    typedef struct {
        logic [N-1:0] mask;
        logic [W-1:0] quo;
        logic [W-1:0] rmd;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int g_cyc    = 0;
    int rsp_cyc  = 0;
    int prev_g   = 0;

    // Core model controls and state.
    int            core_lat;
    logic          ready_en;
    logic          core_busy;
    logic          core_done;
    int            core_cnt;
    logic [W-1:0]  core_a, core_b, core_quo, core_rmd;

    div_arbiter #(.W(W), .N(N), .IW(IW), .TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_dvnd  (req_dvnd),
        .req_dvsr  (req_dvsr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_quo   (rsp_quo),
        .rsp_rmd   (rsp_rmd),
        .rsp_err   (rsp_err),
        .div_start (div_start),
        .div_dvnd  (div_dvnd),
        .div_dvsr  (div_dvsr),
        .div_quo   (div_quo),
        .div_rmd   (div_rmd),
        .div_ready (div_ready),
        .div_done  (div_done),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: done tick core_lat cycles after the start cycle,
    // ready again the cycle after the tick.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_done <= 1'b0;
            core_cnt  <= 0;
            core_a    <= '0;
            core_b    <= '0;
            core_quo  <= '0;
            core_rmd  <= '0;
        end else begin
            core_done <= 1'b0;
            if (div_start && !core_busy) begin
                core_busy <= 1'b1;
                core_cnt  <= core_lat - 1;
                core_a    <= div_dvnd;
                core_b    <= div_dvsr;
            end else if (core_busy) begin
                if (core_done) begin
                    core_busy <= 1'b0;
                end else begin
                    if (core_cnt == 1) begin
                        core_done <= 1'b1;
                        core_quo  <= (core_b == '0) ? '1 : core_a / core_b;
                        core_rmd  <= (core_b == '0) ? core_a : core_a % core_b;
                    end
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    assign div_ready = ready_en & ~core_busy;
    assign div_done  = core_done;
    assign div_quo   = core_quo;
    assign div_rmd   = core_rmd;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse pops and compares one expectation.
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            rsp_cyc = cyc;
            if (sb_q.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(mon_e.mask));
                checkOutput("rsp_quo",   64'(rsp_quo),   64'(mon_e.quo));
                checkOutput("rsp_rmd",   64'(rsp_rmd),   64'(mon_e.rmd));
                checkOutput("rsp_err",   64'(rsp_err),   64'(mon_e.err));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[idx]      = v;
        req_dvnd[idx*W +: W] = a;
        req_dvsr[idx*W +: W] = b;
    endtask

    task automatic pushExp(input int idx, input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
        exp_t x;
        x.mask = N'(1) << idx;
        x.quo  = q;
        x.rmd  = r;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    task automatic waitGrant(input string tag, input logic [N-1:0] exp, input int limit);
        int n = 0;
        #1;
        while (req_ready == '0 && n < limit) begin
            step();
            n++;
        end
        g_cyc = cyc;
        checkOutput(tag, 64'(req_ready), 64'(exp));
    endtask

    task automatic drainScoreboard(input string tag, input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        checkOutput(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int ord[5];
        logic [N-1:0] seen;
        logic         st;

        reset     = 1'b1;
        req_valid = '0;
        req_dvnd  = '0;
        req_dvsr  = '0;
        ready_en  = 1'b1;
        core_lat  = D;
        #1;
        checkOutput("reset_outputs", 64'({req_ready, rsp_valid, rsp_quo, rsp_rmd, rsp_err, div_start,
                                          div_dvnd, div_dvsr, busy, owner}), 64'd0);
        step();
        step();
        reset = 1'b0;

        // Basic operation: requester 2, 100 / 7.
        $display("[TB] basic op");
        pushExp(2, 14, 2, 1'b0);
        applyStimulus(2, 1'b1, 100, 7);
        waitGrant("basic_grant", 4'b0100, 20);
        step();
        checkOutput("basic_start",   64'(div_start), 64'd1);
        checkOutput("basic_dvnd",    64'(div_dvnd),  64'd100);
        checkOutput("basic_dvsr",    64'(div_dvsr),  64'd7);
        checkOutput("basic_ready1",  64'(req_ready), 64'd0);
        applyStimulus(2, 1'b0, 0, 0);
        step();
        checkOutput("basic_start1",  64'(div_start), 64'd0);
        drainScoreboard("basic_drain", 100);
        checkOutput("basic_latency", 64'(rsp_cyc - g_cyc), 64'(2 + D));
        step();
        checkOutput("basic_busy",    64'(busy), 64'd0);

        // Fairness from a fresh rr_ptr with all four requesting continuously.
        $display("[TB] fairness");
        reset = 1'b1;
        step();
        reset = 1'b0;
        ord = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) pushExp(ord[k], 100, W'(ord[k]), 1'b0);
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, W'(1000 + i), 10);
        for (int k = 0; k < 5; k++) begin
            waitGrant($sformatf("fair_grant%0d", k), N'(1) << ord[k], 50);
            if (k > 0) checkOutput($sformatf("fair_spacing%0d", k), 64'(g_cyc - prev_g), 64'(D + 3));
            prev_g = g_cyc;
            step();
            if (k == 4) req_valid = '0;
        end
        drainScoreboard("fair_drain", 100);
        step();

        // Core not ready: requester 1 pending while div_ready is low.
        $display("[TB] core not ready");
        ready_en = 1'b0;
        pushExp(1, 10, 0, 1'b0);
        applyStimulus(1, 1'b1, 50, 5);
        seen = '0;
        st   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen |= req_ready;
            st   |= div_start;
        end
        checkOutput("nr_no_grant", 64'({seen, st}), 64'd0);
        ready_en = 1'b1;
        waitGrant("nr_grant", 4'b0010, 0);
        step();
        checkOutput("nr_start", 64'(div_start), 64'd1);
        applyStimulus(1, 1'b0, 0, 0);
        drainScoreboard("nr_drain", 100);
        step();

        // Timeout: core holds off its tick well past the watchdog limit.
        $display("[TB] timeout");
        core_lat = 40;
        pushExp(3, 0, 0, 1'b1);
        applyStimulus(3, 1'b1, 9, 2);
        waitGrant("to_grant", 4'b1000, 20);
        prev_g = g_cyc;
        step();
        applyStimulus(3, 1'b0, 0, 0);
        drainScoreboard("to_drain", 100);
        checkOutput("to_latency", 64'(rsp_cyc - prev_g), 64'(1 + TMO));
        core_lat = D;
        pushExp(0, 11, 0, 1'b0);
        applyStimulus(0, 1'b1, 77, 7);
        waitGrant("to_next_grant", 4'b0001, 100);
        checkOutput("to_wait_ready", 64'(g_cyc - prev_g), 64'(42));
        checkOutput("to_hold_err",   64'(rsp_err), 64'd1);
        checkOutput("to_hold_quo",   64'({rsp_quo, rsp_rmd}), 64'd0);
        step();
        applyStimulus(0, 1'b0, 0, 0);
        drainScoreboard("to_next_drain", 100);
        step();

        // Done tick lands in the timeout cycle.
        $display("[TB] done/timeout collision");
        core_lat = TMO - 1;
        pushExp(2, 22, 2, 1'b0);
        applyStimulus(2, 1'b1, 200, 9);
        waitGrant("col_grant", 4'b0100, 20);
        step();
        applyStimulus(2, 1'b0, 0, 0);
        drainScoreboard("col_drain", 100);
        checkOutput("col_latency", 64'(rsp_cyc - g_cyc), 64'(1 + TMO));
        step();

        // Reset in WAIT aborts silently; afterwards requester 3 wins from rr_ptr=0.
        $display("[TB] reset mid-op");
        core_lat = D;
        applyStimulus(1, 1'b1, 60, 4);
        waitGrant("rst_first_grant", 4'b0010, 20);
        step();
        applyStimulus(1, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        checkOutput("rst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        applyStimulus(3, 1'b1, 81, 9);
        #1;
        checkOutput("rst_outputs", 64'({req_ready, rsp_valid, rsp_quo, rsp_rmd, rsp_err, div_start,
                                        div_dvnd, div_dvsr, busy, owner}), 64'd0);
        step();
        step();
        pushExp(3, 9, 0, 1'b0);
        reset = 1'b0;
        waitGrant("rst_grant", 4'b1000, 0);
        step();
        checkOutput("rst_owner", 64'(owner), 64'd3);
        applyStimulus(3, 1'b0, 0, 0);
        drainScoreboard("rst_drain", 100);
        checkOutput("rst_latency", 64'(rsp_cyc - g_cyc), 64'(2 + D));
        step();

        // Withdrawal: requester 0 raises and drops its request during another transaction.
        $display("[TB] withdrawal");
        pushExp(1, 8, 1, 1'b0);
        applyStimulus(1, 1'b1, 33, 4);
        waitGrant("wd_grant", 4'b0010, 20);
        step();
        applyStimulus(1, 1'b0, 0, 0);
        applyStimulus(0, 1'b1, 5, 1);
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= req_ready;
        end
        applyStimulus(0, 1'b0, 0, 0);
        drainScoreboard("wd_drain", 100);
        for (int i = 0; i < 20; i++) begin
            step();
            seen |= req_ready;
        end
        checkOutput("wd_no_grant", 64'(seen), 64'd0);
        checkOutput("final_queue", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one sequential divider core (start/ready/done-tick interface) between N independent requesters.
- Arbitrates round-robin, registers the winner's operands and pulses the core's start. Captures quotient/remainder on the core's done tick and returns them to the owning requester.
- A watchdog aborts a transaction whose done tick never arrives. Sits between client logic (CPU slave wrappers, accelerators) and the divider core.

Parameters:
W, 32, operand/result width in bits
N, 4, number of requesters (2..8)
IW, 2, owner index width, ceil(log2(N))
TMO, 256, watchdog limit in cycles spent in WAIT (>= core latency + 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
req_valid  in  N  request pending, per requester
req_dvnd  in  N*W  dividends; requester i at [i*W +: W]
req_dvsr  in  N*W  divisors; same packing
req_ready  out  N  one-cycle accept pulse to the granted requester
rsp_valid  out  N  one-cycle result pulse to the owning requester
rsp_quo  out  W  shared quotient bus, valid with rsp_valid
rsp_rmd  out  W  shared remainder bus, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
div_start  out  1  start pulse to core
div_dvnd  out  W  registered dividend to core
div_dvsr  out  W  registered divisor to core
div_quo  in  W  core quotient
div_rmd  in  W  core remainder
div_ready  in  1  core idle
div_done  in  1  core one-cycle completion tick
busy  out  1  transaction in progress
owner  out  IW  index of current or last granted requester

Behaviour:
- Clock/reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, watchdog=0; all outputs 0.
- Reset mid-operation aborts silently: no rsp_valid is issued.
- The core is reset by the same reset; no handshake with it is needed.
- Requester contract: hold req_valid and operands stable until req_ready.
  - Dropping req_valid before grant is legal; the request is forgotten.
  - After req_ready, the requester may change its inputs freely.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Grant only when |req_valid and div_ready=1.
  - Winner g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N.
  - Same cycle: req_ready[g]=1 (combinational, Moore-qualified by state).
  - Registered on that edge: div_dvnd, div_dvsr <= requester g operands; owner <= g.
  - Next state LAUNCH.
  - If div_ready=0, stay in IDLE with no grant.
- LAUNCH: div_start=1 for exactly one cycle; watchdog <= 0; next WAIT.
- WAIT:
  - watchdog increments each cycle.
  - On div_done: rsp_quo <= div_quo, rsp_rmd <= div_rmd, rsp_err <= 0; next RESP.
  - If watchdog reaches TMO-1 without div_done: rsp_quo=0, rsp_rmd=0, rsp_err <= 1; next RESP.
  - div_done on that same cycle wins: normal result, rsp_err=0.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - rr_ptr <= (owner+1) mod N.
  - Next IDLE.
  - No grant is made in this cycle even if requests are pending.
- div_done outside WAIT is ignored, e.g. a late tick after a timeout.
- After a timeout, the next grant still waits for div_ready.
- rsp_quo, rsp_rmd and rsp_err hold their last values between responses.
- busy = (state != IDLE).
- Latency: grant at cycle T, div_start at T+1, rsp_valid at T+2+D, where D is the core cycles from start to done.
- Minimum request-to-request spacing: D+3 cycles.
- Divide-by-zero is not special-cased; core outputs are passed through unmodified.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 transactions.

Test Plan:
- Basic op (bench core model, D=W+2):
  - Stimulus: requester 2 sends dvnd=100, dvsr=7.
  - Required: req_ready=4'b0100 for one cycle; div_start one cycle later with div_dvnd=100, div_dvsr=7.
  - Required: rsp_valid=4'b0100 at T+2+D with rsp_quo=14, rsp_rmd=2, rsp_err=0; busy low after.
- Fairness:
  - Stimulus: all 4 requesters hold req_valid, each with dvnd=1000+i, dvsr=10.
  - Required: grant order 0,1,2,3,0; each rsp_valid pulses only its own bit with quo=100, rmd=i.
- Core not ready:
  - Stimulus: hold div_ready=0 for 20 cycles while requester 1 is pending.
  - Required: no req_ready and no div_start; grant occurs on the first cycle div_ready=1.
- Timeout:
  - Stimulus: TMO=16, core model never asserts div_done.
  - Required: rsp_valid pulses for the owner 16 cycles after LAUNCH with rsp_err=1, quo=0, rmd=0.
  - Required: a late div_done is ignored; the next request is serviced normally.
- Done/timeout collision:
  - Stimulus: div_done asserted in the timeout cycle.
  - Required: rsp_err=0 and the core's quo/rmd are returned.
- Reset mid-op:
  - Stimulus: assert reset in WAIT.
  - Required: all outputs 0 immediately, no rsp_valid issued.
  - Required: after release, requester 3 alone is granted (rr_ptr=0, search wraps to 3) and completes normally.
- Withdrawal:
  - Stimulus: requester 0 drops req_valid while the arbiter is in WAIT for requester 1.
  - Required: requester 0 is never granted and no rsp_valid[0] occurs.
